// File: rtl/stage_evaluator.sv
// stage_evaluator: cascade-stage sequencer and weak-classifier comparator for one detection window.
// Fetches stage and feature thresholds, accumulates leaf values and reports pass/fail per window.
module stage_evaluator #(
    parameter int W_DATA   = 13,
    parameter int W_ADDR   = 12,
    parameter int W_LEAF   = 13,
    parameter int W_FEAT   = 32,
    parameter int W_STD    = 16,
    parameter int W_ACC    = 18,
    parameter int W_NFEAT  = 8,
    parameter int W_STAGE  = 5,
    parameter int N_STAGES = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W_STD-1:0]   std_dev,
    output logic               busy,
    output logic               thr_en,
    output logic [W_ADDR-1:0]  thr_addr,
    input  logic [W_DATA-1:0]  thr_data,
    input  logic [W_LEAF-1:0]  left_val,
    input  logic [W_LEAF-1:0]  right_val,
    output logic               stage_en,
    output logic [W_STAGE-1:0] stage_addr,
    input  logic [W_ACC-1:0]   stage_thr,
    input  logic [W_NFEAT-1:0] stage_nfeat,
    output logic               feat_req,
    input  logic               feat_valid,
    input  logic [W_FEAT-1:0]  feat_sum,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               result,
    output logic [W_STAGE-1:0] fail_stage
);
    localparam int W_P = W_DATA + W_STD + 1;
    localparam int W_C = W_FEAT > W_P ? W_FEAT : W_P;

    typedef enum logic [3:0] {IDLE, STG_RD, STG_LAT, FT_RD, FT_LAT, FT_WAIT, EVAL, STG_CHK, DONE} state_t;
    state_t state, state_nx;

    logic [W_STD-1:0]          std_q;
    logic [W_STAGE-1:0]        sidx;
    logic [W_ADDR-1:0]         fidx;
    logic [W_NFEAT-1:0]        nfeat, fcnt;
    logic signed [W_ACC-1:0]   sthr, acc, acc_nx;
    logic signed [W_ACC:0]     sum;
    logic signed [W_LEAF-1:0]  left_q, right_q, leaf;
    logic signed [W_P-1:0]     prod;
    logic signed [W_FEAT-1:0]  feat_q;
    logic                      last_feat, last_stage, stage_fail;

    assign last_feat  = fcnt == nfeat - W_NFEAT'(1);
    assign last_stage = sidx == W_STAGE'(N_STAGES - 1);
    assign stage_fail = acc < sthr;
    assign leaf       = (W_C'(feat_q) < W_C'(prod)) ? left_q : right_q;
    assign sum        = {acc[W_ACC-1], acc} + (W_ACC+1)'(leaf);
    // clamp to the extreme of the overflow direction instead of wrapping
    assign acc_nx     = (sum[W_ACC] ^ sum[W_ACC-1]) ? {sum[W_ACC], {(W_ACC-1){~sum[W_ACC]}}} : sum[W_ACC-1:0];

    assign busy         = state != IDLE;
    assign thr_en       = state == FT_RD;
    assign feat_req     = state == FT_RD;
    assign stage_en     = state == STG_RD;
    assign result_valid = state == DONE;
    assign thr_addr     = fidx;
    assign stage_addr   = sidx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:            state_nx = start ? STG_RD : IDLE;
            STG_RD:          state_nx = STG_LAT;
            STG_LAT:         state_nx = (stage_nfeat == '0) ? STG_CHK : FT_RD;
            FT_RD:           state_nx = FT_LAT;
            FT_LAT, FT_WAIT: state_nx = feat_valid ? EVAL : FT_WAIT;
            EVAL:            state_nx = last_feat ? STG_CHK : FT_RD;
            STG_CHK:         state_nx = (stage_fail || last_stage) ? DONE : STG_RD;
            DONE:            state_nx = result_ready ? IDLE : DONE;
            default:         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            std_q      <= '0;
            sidx       <= '0;
            fidx       <= '0;
            nfeat      <= '0;
            fcnt       <= '0;
            sthr       <= '0;
            acc        <= '0;
            left_q     <= '0;
            right_q    <= '0;
            prod       <= '0;
            feat_q     <= '0;
            result     <= 1'b0;
            fail_stage <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    std_q <= std_dev;
                    sidx  <= '0;
                    fidx  <= '0;
                end
                STG_LAT: begin
                    sthr  <= stage_thr;
                    nfeat <= stage_nfeat;
                    acc   <= '0;
                    fcnt  <= '0;
                end
                FT_LAT: begin
                    left_q  <= left_val;
                    right_q <= right_val;
                    prod    <= W_P'($signed(thr_data)) * W_P'($signed({1'b0, std_q}));
                    if (feat_valid) feat_q <= feat_sum;
                end
                FT_WAIT: if (feat_valid) feat_q <= feat_sum;
                EVAL: begin
                    acc  <= acc_nx;
                    fidx <= fidx + W_ADDR'(1);
                    fcnt <= fcnt + W_NFEAT'(1);
                end
                STG_CHK: begin
                    if (stage_fail || last_stage) begin
                        result     <= ~stage_fail;
                        fail_stage <= sidx;
                    end else sidx <= sidx + W_STAGE'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
